alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Sequential front end that drives the combinational ALU (ports in1_val, in2_val, mux_in, c_in).
//  It takes operation requests over a valid/ready handshake and reads the operands from a local register file.
//  It presents the operands and opcode to the ALU as registered signals, then captures out1_val and c_out.
//  It writes the result back and returns it over a second valid/ready handshake.
// PARAMETERS
//  N      32  operand/result width; must match the ALU N
//  REGS   8   register file depth (power of 2); AW = $clog2(REGS)
// PORTS
//  clk        in   1   single clock, all state on rising edge
//  rst_n      in   1   synchronous active-low reset
//  req_valid  in   1   request present
//  req_ready  out  1   block can accept a request (IDLE only)
//  req_op     in   3   ALU opcode: 000 MOV, 001 NOT, 010 ADD, 011 NOR, 100 SUB, 101 NAND, 110 AND, 111 SLT
//  req_rs1    in   AW  operand-1 register index
//  req_rs2    in   AW  operand-2 register index
//  req_rd     in   AW  destination register index
//  req_cin    in   1   carry-in for ADD/SUB
//  alu_in1    out  N   to ALU in1_val (registered)
//  alu_in2    out  N   to ALU in2_val (registered)
//  alu_mux    out  3   to ALU mux_in (registered)
//  alu_cin    out  1   to ALU c_in (registered)
//  alu_res    in   N   from ALU out1_val
//  alu_cout   in   1   from ALU c_out
//  resp_valid out  1   result available
//  resp_ready in   1   consumer accepts result
//  resp_data  out  N   result value
//  resp_carry out  1   carry flag; 0 unless the op is ADD or SUB
//  wr_en      in   1   external register preload strobe
//  wr_addr    in   AW  preload index
//  wr_data    in   N   preload value
//  wr_drop    out  1   sticky: a preload arrived outside IDLE and was discarded
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): state=IDLE; every register file entry=0.
//   All outputs =0, except req_ready, which is 1 in the first cycle after reset.
//   A reset in any state abandons the operation in flight; there is no partial writeback.
//  FSM: IDLE -> OPER -> EXEC -> RESP -> IDLE.
//   IDLE: req_ready=1. Handshake fires when req_valid=1 at an edge.
//    That edge latches op, rs1, rs2, rd and cin, and the state goes to OPER.
//   OPER: at the end edge, alu_in1=RF[rs1], alu_in2=RF[rs2], alu_mux=op and alu_cin=cin; state goes to EXEC.
//   EXEC: the ALU settles combinationally.
//    At the end edge, resp_data=alu_res and resp_carry=alu_cout&(op==ADD|op==SUB).
//    At the same edge, RF[rd] is written with alu_res; state goes to RESP.
//   RESP: resp_valid=1; resp_data and resp_carry are held stable.
//    Leaves for IDLE on the edge where resp_ready=1.
//  Latency: resp_valid rises 3 edges after the request edge. Minimum issue interval is 4 cycles.
//  Register 0 always reads as 0. Writes to it (writeback or preload) are discarded.
//   resp_data still reports the ALU result when rd=0.
//  Read-after-write: the next request sees the previous writeback, because RF is updated at the end of EXEC.
//  Preload: wr_en is honoured only in IDLE, at the same edge as any request handshake.
//   It is visible to that request's OPER read.
//   If wr_en=1 in any other state, the write is dropped and wr_drop is set; only reset clears wr_drop.
//  alu_in*/alu_mux/alu_cin hold their last values outside OPER; they change only at the OPER end edge.
//  Arithmetic is entirely inside the ALU. This block does not modify result bits; width is N throughout.
//  req_ready=0 in OPER, EXEC and RESP; requests are not buffered.
// TESTING
//  Reset, then preload R1=5, R2=3, then ADD rd=3 cin=0 ->
//   resp_valid 3 edges after the request; resp_data=8, resp_carry=0; a following MOV from R3 returns 8.
//  Preload R1=FFFFFFFF, R2=1, then ADD cin=0 rd=4 -> resp_data=0, resp_carry=1.
//   SLT R2,R1 -> resp_carry=0 (flag masked).
//  Hold resp_ready=0 for 5 cycles in RESP ->
//   resp_valid and resp_data stay stable, req_ready=0, and a new req_valid is ignored.
//  Issue an op with rd=0 -> resp_data shows the ALU result; a subsequent read of R0 returns 0.
//  Pulse wr_en during EXEC -> the RF entry is unchanged and wr_drop=1 until the next reset.
//  Assert rst_n=0 during EXEC of ADD to R5 (R5 previously 7) ->
//   R5=0 after reset, resp_valid never rises, and req_ready=1 in the next cycle.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
// Sequential front end for a combinational ALU. It accepts an operation
// request over a valid/ready handshake and reads both operands from a local
// register file. It presents operands, opcode and carry-in to the ALU as
// registered signals, then captures the ALU result. The result is written
// back to the register file and returned over a response handshake.
//
// Ports
//   clk         single clock, all state on the rising edge
//   rst_n       synchronous active-low reset
//   req_valid   request present            req_ready   accepting (IDLE only)
//   req_op      ALU opcode (000 MOV .. 111 SLT)
//   req_rs1/2   operand register indices   req_rd      destination index
//   req_cin     carry-in for ADD/SUB
//   alu_in1/2   registered operands to the ALU
//   alu_mux     registered opcode to the ALU
//   alu_cin     registered carry-in to the ALU
//   alu_res     ALU result                 alu_cout    ALU carry-out
//   resp_valid  result available           resp_ready  consumer accepts
//   resp_data   result value               resp_carry  carry (ADD/SUB only)
//   wr_en/wr_addr/wr_data  register preload, honoured only in IDLE
//   wr_drop     sticky flag: a preload arrived outside IDLE
// ---------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter  int N    = 32,
    parameter  int REGS = 8,
    localparam int AW   = $clog2(REGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    req_op,
    input  logic [AW-1:0] req_rs1,
    input  logic [AW-1:0] req_rs2,
    input  logic [AW-1:0] req_rd,
    input  logic          req_cin,
    output logic [N-1:0]  alu_in1,
    output logic [N-1:0]  alu_in2,
    output logic [2:0]    alu_mux,
    output logic          alu_cin,
    input  logic [N-1:0]  alu_res,
    input  logic          alu_cout,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [N-1:0]  resp_data,
    output logic          resp_carry,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [N-1:0]  wr_data,
    output logic          wr_drop
);

    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OPER = 2'd1,
        ST_EXEC = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t        r_state;
    logic [N-1:0]  r_rf [REGS];
    logic [2:0]    r_op;
    logic [AW-1:0] r_rs1;
    logic [AW-1:0] r_rs2;
    logic [AW-1:0] r_rd;
    logic          r_cin;
    logic          r_req_ready;
    logic [N-1:0]  r_alu_in1;
    logic [N-1:0]  r_alu_in2;
    logic [2:0]    r_alu_mux;
    logic          r_alu_cin;
    logic          r_resp_valid;
    logic [N-1:0]  r_resp_data;
    logic          r_resp_carry;
    logic          r_wr_drop;

    logic [N-1:0]  w_rs1_data;
    logic [N-1:0]  w_rs2_data;
    logic          w_carry_op;

    // Register 0 is hardwired to zero on the read side as well as never written.
    assign w_rs1_data = (r_rs1 == '0) ? '0 : r_rf[r_rs1];
    assign w_rs2_data = (r_rs2 == '0) ? '0 : r_rf[r_rs2];
    assign w_carry_op = (r_op == OP_ADD) || (r_op == OP_SUB);

    // Issue FSM, register file and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            for (int i = 0; i < REGS; i++) begin
                r_rf[i] <= '0;
            end
            r_op         <= 3'b000;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_rd         <= '0;
            r_cin        <= 1'b0;
            r_req_ready  <= 1'b1;
            r_alu_in1    <= '0;
            r_alu_in2    <= '0;
            r_alu_mux    <= 3'b000;
            r_alu_cin    <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_carry <= 1'b0;
            r_wr_drop    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Preload lands at the request edge so the OPER read sees it.
                    if (wr_en && (wr_addr != '0)) begin
                        r_rf[wr_addr] <= wr_data;
                    end
                    if (req_valid) begin
                        r_op        <= req_op;
                        r_rs1       <= req_rs1;
                        r_rs2       <= req_rs2;
                        r_rd        <= req_rd;
                        r_cin       <= req_cin;
                        r_req_ready <= 1'b0;
                        r_state     <= ST_OPER;
                    end
                end
                ST_OPER: begin
                    r_alu_in1 <= w_rs1_data;
                    r_alu_in2 <= w_rs2_data;
                    r_alu_mux <= r_op;
                    r_alu_cin <= r_cin;
                    r_state   <= ST_EXEC;
                end
                ST_EXEC: begin
                    r_resp_data  <= alu_res;
                    r_resp_carry <= alu_cout & w_carry_op;
                    r_resp_valid <= 1'b1;
                    if (r_rd != '0) begin
                        r_rf[r_rd] <= alu_res;
                    end
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                    r_state      <= ST_IDLE;
                end
            endcase
            // A preload outside IDLE is discarded and remembered until reset.
            if (wr_en && (r_state != ST_IDLE)) begin
                r_wr_drop <= 1'b1;
            end
        end
    end

    assign req_ready  = r_req_ready;
    assign alu_in1    = r_alu_in1;
    assign alu_in2    = r_alu_in2;
    assign alu_mux    = r_alu_mux;
    assign alu_cin    = r_alu_cin;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_carry = r_resp_carry;
    assign wr_drop    = r_wr_drop;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

    localparam int N  = 32;
    localparam int AW = 3;

    localparam logic [2:0] OP_MOV  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_NAND = 3'b101;
    localparam logic [2:0] OP_AND  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;
    localparam logic [2:0] OP_NOT  = 3'b001;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_op;
    logic [AW-1:0] req_rs1;
    logic [AW-1:0] req_rs2;
    logic [AW-1:0] req_rd;
    logic          req_cin;
    logic [N-1:0]  alu_in1;
    logic [N-1:0]  alu_in2;
    logic [2:0]    alu_mux;
    logic          alu_cin;
    logic [N-1:0]  alu_res;
    logic          alu_cout;
    logic          resp_valid;
    logic          resp_ready;
    logic [N-1:0]  resp_data;
    logic          resp_carry;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [N-1:0]  wr_data;
    logic          wr_drop;

    int n_vec;
    int n_err;

    alu_issue_ctrl #(.N(N), .REGS(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_rd     (req_rd),
        .req_cin    (req_cin),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_mux    (alu_mux),
        .alu_cin    (alu_cin),
        .alu_res    (alu_res),
        .alu_cout   (alu_cout),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_carry (resp_carry),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_drop    (wr_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stand-in for the external combinational ALU.
    // SUB reports borrow on cout; SLT drives cout with unsigned less-than
    // so that the masking of the carry flag is observable.
    always_comb begin
        alu_res  = '0;
        alu_cout = 1'b0;
        case (alu_mux)
            3'b000: alu_res = alu_in1;
            3'b001: alu_res = ~alu_in1;
            3'b010: {alu_cout, alu_res} = {1'b0, alu_in1} + {1'b0, alu_in2} + {32'd0, alu_cin};
            3'b011: alu_res = ~(alu_in1 | alu_in2);
            3'b100: {alu_cout, alu_res} = {1'b0, alu_in1} - {1'b0, alu_in2} - {32'd0, alu_cin};
            3'b101: alu_res = ~(alu_in1 & alu_in2);
            3'b110: alu_res = alu_in1 & alu_in2;
            3'b111: begin
                alu_res  = ($signed(alu_in1) < $signed(alu_in2)) ? 32'd1 : 32'd0;
                alu_cout = (alu_in1 < alu_in2);
            end
            default: alu_res = '0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [N-1:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Drive a request for one edge; outputs are sampled on falling edges.
    task automatic send_req(input logic [2:0] op, input logic [AW-1:0] rs1,
                            input logic [AW-1:0] rs2, input logic [AW-1:0] rd,
                            input logic cin);
        req_valid = 1'b1;
        req_op    = op;
        req_rs1   = rs1;
        req_rs2   = rs2;
        req_rd    = rd;
        req_cin   = cin;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Full transaction: returns result, carry and the edge count from the
    // request edge (inclusive) to the edge that raised resp_valid.
    task automatic issue(input logic [2:0] op, input logic [AW-1:0] rs1,
                         input logic [AW-1:0] rs2, input logic [AW-1:0] rd,
                         input logic cin, output logic [N-1:0] data,
                         output logic carry, output int edges);
        @(negedge clk);
        send_req(op, rs1, rs2, rd, cin);
        edges = 1;
        while (!resp_valid && edges < 12) begin
            @(negedge clk);
            edges++;
        end
        data  = resp_data;
        carry = resp_carry;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    logic [N-1:0] d;
    logic         c;
    int           e;
    logic [N-1:0] held;

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0; req_valid = 1'b0; req_op = 3'b000; req_rs1 = '0;
        req_rs2 = '0; req_rd = '0; req_cin = 1'b0; resp_ready = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_resp_carry", {31'd0, resp_carry}, 32'd0);
        check("rst_alu_in1", alu_in1, 32'd0);
        check("rst_alu_in2", alu_in2, 32'd0);
        check("rst_alu_mux_cin", {28'd0, alu_mux, alu_cin}, 32'd0);
        check("rst_wr_drop", {31'd0, wr_drop}, 32'd0);
        rst_n = 1'b1;

        // Basic ADD, latency and read-after-write
        preload(3'd1, 32'd5);
        preload(3'd2, 32'd3);
        issue(OP_ADD, 3'd1, 3'd2, 3'd3, 1'b0, d, c, e);
        check("add_latency", e, 32'd3);
        check("add_data", d, 32'd8);
        check("add_carry", {31'd0, c}, 32'd0);
        check("add_ready_back", {31'd0, req_ready}, 32'd1);
        issue(OP_MOV, 3'd3, 3'd0, 3'd6, 1'b0, d, c, e);
        check("mov_r3", d, 32'd8);
        check("mov_alu_mux", {29'd0, alu_mux}, 32'd0);
        check("mov_alu_in1_held", alu_in1, 32'd8);

        // Carry out of ADD, masked carry on SLT, SUB borrow, NAND
        preload(3'd1, 32'hFFFF_FFFF);
        preload(3'd2, 32'd1);
        issue(OP_ADD, 3'd1, 3'd2, 3'd4, 1'b0, d, c, e);
        check("add_wrap_data", d, 32'd0);
        check("add_wrap_carry", {31'd0, c}, 32'd1);
        issue(OP_SLT, 3'd2, 3'd1, 3'd7, 1'b0, d, c, e);
        check("slt_data", d, 32'd0);
        check("slt_carry_masked", {31'd0, c}, 32'd0);
        issue(OP_SUB, 3'd2, 3'd1, 3'd7, 1'b0, d, c, e);
        check("sub_data", d, 32'd2);
        check("sub_carry", {31'd0, c}, 32'd1);
        issue(OP_NAND, 3'd1, 3'd2, 3'd7, 1'b0, d, c, e);
        check("nand_data", d, 32'hFFFF_FFFE);
        check("nand_carry", {31'd0, c}, 32'd0);
        issue(OP_ADD, 3'd2, 3'd2, 3'd7, 1'b1, d, c, e);
        check("add_cin_data", d, 32'd3);

        // Back-pressure in RESP, AND into rd=0, ignored request
        @(negedge clk);
        send_req(OP_AND, 3'd1, 3'd2, 3'd0, 1'b0);
        repeat (2) @(negedge clk);
        check("bp_valid_rise", {31'd0, resp_valid}, 32'd1);
        check("rd0_data", resp_data, 32'd1);
        held = resp_data;
        req_valid = 1'b1; req_op = OP_NOT; req_rs1 = 3'd1; req_rd = 3'd6;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid_hold", {31'd0, resp_valid}, 32'd1);
            check("bp_data_hold", resp_data, held);
            check("bp_ready_low", {31'd0, req_ready}, 32'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("bp_release_valid", {31'd0, resp_valid}, 32'd0);
        check("bp_release_ready", {31'd0, req_ready}, 32'd1);
        repeat (3) @(negedge clk);
        check("bp_no_ghost_valid", {31'd0, resp_valid}, 32'd0);
        check("bp_no_ghost_ready", {31'd0, req_ready}, 32'd1);
        issue(OP_MOV, 3'd6, 3'd0, 3'd7, 1'b0, d, c, e);
        check("ignored_req_r6", d, 32'd8);
        issue(OP_MOV, 3'd0, 3'd0, 3'd7, 1'b0, d, c, e);
        check("r0_after_wb", d, 32'd0);
        preload(3'd0, 32'h1234_5678);
        issue(OP_MOV, 3'd0, 3'd0, 3'd7, 1'b0, d, c, e);
        check("r0_after_preload", d, 32'd0);

        // Preload during EXEC is dropped and sticky
        @(negedge clk);
        send_req(OP_ADD, 3'd2, 3'd2, 3'd7, 1'b0);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 32'h0000_DEAD;
        @(negedge clk);
        wr_en = 1'b0;
        check("drop_flag", {31'd0, wr_drop}, 32'd1);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        issue(OP_MOV, 3'd1, 3'd0, 3'd7, 1'b0, d, c, e);
        check("drop_rf_unchanged", d, 32'hFFFF_FFFF);
        check("drop_sticky", {31'd0, wr_drop}, 32'd1);

        // Reset during EXEC abandons the writeback
        preload(3'd5, 32'd7);
        issue(OP_MOV, 3'd5, 3'd0, 3'd7, 1'b0, d, c, e);
        check("r5_preloaded", d, 32'd7);
        @(negedge clk);
        send_req(OP_ADD, 3'd1, 3'd2, 3'd5, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_exec_ready", {31'd0, req_ready}, 32'd1);
        check("rst_exec_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_exec_drop_clr", {31'd0, wr_drop}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("rst_exec_no_valid", {31'd0, resp_valid}, 32'd0);
        end
        issue(OP_MOV, 3'd5, 3'd0, 3'd7, 1'b0, d, c, e);
        check("rst_exec_r5", d, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
